alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Multi-cycle controller that shares the single 32-bit integer ALU between two requesters: requester 0 is the core datapath and requester 1 is the address/auxiliary unit. It arbitrates round-robin and registers the winning operation onto the ALU input ports. It then captures the ALU result and flag, and returns them to the winner through a valid/ready response channel. At most one operation is in flight.

Parameters:
DATA_W, 32, operand/result width; matches the ALU datapath.
OP_W, 6, opcode and funct field width.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_opcode  input  OP_W  opcode (0 = register-form, 1 = addi, 4 = xori)
req0_funct  input  OP_W  funct for opcode 0 (0 add, 2 sub, 10 xor)
req0_a  input  DATA_W  operand A
req0_b  input  DATA_W  operand B
req1_valid/req1_ready/req1_opcode/req1_funct/req1_a/req1_b  as requester 0
alu_opcode  output  OP_W  registered, to ALU opcode
alu_funct  output  OP_W  registered, to ALU funct
alu_srca  output  DATA_W  registered, to ALU SrcA
alu_srcb  output  DATA_W  registered, to ALU SrcB
alu_out  input  DATA_W  ALU result (combinational from the registered inputs)
alu_flag  input  1  ALU carry-out (bit 32 of the 33-bit sum)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that owns the result
rsp_data  output  DATA_W  captured alu_out
rsp_flag  output  1  captured alu_flag

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state = IDLE; rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_flag = 0; all alu_* outputs = 0; req*_ready = 0; last_grant = 1, so requester 0 wins first.
- IDLE: the grant is combinational from req*_valid.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - reqN_ready = grantN, and is asserted only in IDLE.
  - On accept: latch opcode, funct, a and b into the alu_* registers; latch rsp_id = N; set last_grant = N; go to EXEC.
- EXEC (1 cycle): the ALU evaluates. At the end of the cycle, capture alu_out into rsp_data and alu_flag into rsp_flag, set rsp_valid = 1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_data and rsp_flag stable until rsp_ready = 1.
  - On the handshake: clear rsp_valid and go to IDLE.
  - No accept is allowed in the handshake cycle.
- Timing:
  - Accept at cycle N; rsp_valid = 1 at cycle N+2.
  - Minimum spacing between accepts is 3 cycles.
- alu_* registers keep their last value outside EXEC; there is no clearing.
- No ready is asserted while a requester's valid is low. Once asserted, a requester must hold valid and its fields until ready.
- Flag is the raw carry-out: 0xFFFFFFFF + 1 gives data 0, flag 1. The flag is not interpreted for sub or xor.
- rst asserted in any state returns to the reset values immediately; an in-flight operation is dropped with no response.

Optional Feature:
ALU_SHARE_STATS_EN
- Defined: adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on its requester's accept and saturates at 0xFFFF.
  - Both reset to 0.
  - Counting has no effect on timing.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_share_pkg:
  - state encoding (IDLE/EXEC/RESP);
  - OP_RTYPE = 0, OP_ADDI = 1, OP_XORI = 4;
  - FN_ADD = 0, FN_SUB = 2, FN_XOR = 10;
  - DATA_W and OP_W defaults.
- One sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register and an update-on-accept input.

Test Plan:
- Reset first-grant: req0 only, opcode 1, a = 5, b = 7 -> req0_ready in cycle 0; rsp_valid cycle 2 with rsp_id 0, rsp_data 12, rsp_flag 0.
- Sub and xor via register form:
  - req1, opcode 0, funct 2, a = 10, b = 3 -> rsp_data 7, rsp_id 1.
  - opcode 0, funct 10, a = 0xF0F0F0F0, b = 0xFFFF0000 -> rsp_data 0x0F0FF0F0.
- Overflow: opcode 1, a = 0xFFFFFFFF, b = 1 -> rsp_data 0, rsp_flag 1.
- Fairness: req0 and req1 held valid continuously for 4 operations -> grants alternate 0, 1, 0, 1; accepts exactly 3 cycles apart when rsp_ready is tied high.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid -> rsp_* stable throughout, no req*_ready asserted, state returns to IDLE one cycle after rsp_ready rises.
- Reset mid-op: assert rst during EXEC -> rsp_valid stays 0, alu_* outputs = 0, and the next req1-only request is granted normally.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU share controller.
// Optional grant statistics are built when ALU_SHARE_STATS_EN is defined.
package alu_share_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_XORI  = 6'd4;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_XOR = 6'd10;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the winner of the last accept loses a tie.
// Reset leaves last_grant at 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = valid;
    if (&valid) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b1;
    else if (update) last_grant <= grant[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters, one operation in flight at a time.
// Define ALU_SHARE_STATS_EN to add saturating per-requester grant counters.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [OP_W-1:0]   req0_funct,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [OP_W-1:0]   req1_funct,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [OP_W-1:0]   alu_funct,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flag
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  state_t     state, state_nx;
  logic [1:0] grant;
  logic       idle;
  logic       accept;

  // Ready is masked during reset so nothing is accepted while it is held.
  assign idle       = (state == IDLE) && !rst;
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign accept     = req0_ready || req1_ready;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_srca   <= '0;
      alu_srcb   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      if (accept) begin
        alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
        alu_funct  <= grant[1] ? req1_funct : req0_funct;
        alu_srca   <= grant[1] ? req1_a : req0_a;
        alu_srcb   <= grant[1] ? req1_b : req0_b;
        rsp_id     <= grant[1];
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_flag  <= alu_flag;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU and
// a transaction-level arbitration and timing model.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        flag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready;
  logic [5:0]  req0_opcode, req0_funct;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [5:0]  req1_opcode, req1_funct;
  logic [31:0] req1_a, req1_b;
  logic [5:0]  alu_opcode, alu_funct;
  logic [31:0] alu_srca, alu_srcb, alu_out;
  logic        alu_flag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [31:0] rsp_data;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_funct  (req0_funct),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_funct  (req1_funct),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .alu_opcode  (alu_opcode),
    .alu_funct   (alu_funct),
    .alu_srca    (alu_srca),
    .alu_srcb    (alu_srcb),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_flag    (rsp_flag)
`ifdef ALU_SHARE_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  // {carry, result}; carry is the raw adder carry of a + b.
  function automatic logic [32:0] alu_ref(
    input logic [5:0] op, input logic [5:0] fn,
    input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = 32'h0;
    if (op == 6'd1) r = a + b;
    else if (op == 6'd4) r = a ^ b;
    else if (op == 6'd0) begin
      if (fn == 6'd0) r = a + b;
      else if (fn == 6'd2) r = a - b;
      else if (fn == 6'd10) r = a ^ b;
    end
    return {s[32], r};
  endfunction

  assign {alu_flag, alu_out} = alu_ref(alu_opcode, alu_funct, alu_srca, alu_srcb);

  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  op_t  q0[$], q1[$];
  exp_t sb[$];
  logic acc0 = 0, acc1 = 0;
  logic acc_ids[$];
  int   acc_cycs[$];
  int   cyc = 0;
  logic midle = 1, mlast = 1;
  logic last_id, last_flag;
  logic [31:0] last_data;

  logic rand_rdy = 0, rdy_force = 1, rr = 1;
  assign rsp_ready = rand_rdy ? rr : rdy_force;

  initial forever begin
    @(posedge clk); #1;
    rr = ($urandom_range(0, 3) != 0);
  end

  initial begin
    req0_valid = 0; req0_opcode = 0; req0_funct = 0; req0_a = 0; req0_b = 0;
    forever begin
      @(posedge clk); #1;
      if (acc0) begin void'(q0.pop_front()); acc0 = 0; req0_valid = 0; end
      if (rst) req0_valid = 0;
      else if (!req0_valid && q0.size() > 0) begin
        req0_opcode = q0[0].op; req0_funct = q0[0].fn;
        req0_a = q0[0].a; req0_b = q0[0].b; req0_valid = 1;
      end
    end
  end

  initial begin
    req1_valid = 0; req1_opcode = 0; req1_funct = 0; req1_a = 0; req1_b = 0;
    forever begin
      @(posedge clk); #1;
      if (acc1) begin void'(q1.pop_front()); acc1 = 0; req1_valid = 0; end
      if (rst) req1_valid = 0;
      else if (!req1_valid && q1.size() > 0) begin
        req1_opcode = q1[0].op; req1_funct = q1[0].fn;
        req1_a = q1[0].a; req1_b = q1[0].b; req1_valid = 1;
      end
    end
  end

  // Monitor: arbitration, latency, hold-stability and response scoreboard.
  initial begin
    logic        hold_v, h_id, h_flag, id, lat_p;
    logic [31:0] h_data;
    logic [1:0]  e;
    logic [32:0] x;
    int          acc_cyc;
    exp_t        ex;
    hold_v = 0; lat_p = 0; acc_cyc = 0; h_id = 0; h_flag = 0; h_data = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete(); midle = 1; mlast = 1; hold_v = 0; lat_p = 0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_id", rsp_id, h_id);
          chk("hold_data", rsp_data, h_data);
          chk("hold_flag", rsp_flag, h_flag);
        end
        e = 2'b00;
        if (midle) begin
          if (req0_valid && req1_valid) e = mlast ? 2'b01 : 2'b10;
          else e = {req1_valid, req0_valid};
        end
        chk("grant", {req1_ready, req0_ready}, e);
        if (lat_p && cyc == acc_cyc + 1) chk("lat_exec", rsp_valid, 0);
        if (lat_p && cyc == acc_cyc + 2) begin
          chk("lat_rsp", rsp_valid, 1);
          lat_p = 0;
        end
        if (req0_ready || req1_ready) begin
          id = req1_ready;
          if (id) x = alu_ref(req1_opcode, req1_funct, req1_a, req1_b);
          else x = alu_ref(req0_opcode, req0_funct, req0_a, req0_b);
          sb.push_back('{id: id, data: x[31:0], flag: x[32]});
          if (id) acc1 = 1; else acc0 = 1;
          mlast = id; midle = 0; acc_cyc = cyc; lat_p = 1;
          acc_ids.push_back(id);
          acc_cycs.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) fail_now("rsp_unexpected");
          else begin
            ex = sb.pop_front();
            chk("rsp_id", rsp_id, ex.id);
            chk("rsp_data", rsp_data, ex.data);
            chk("rsp_flag", rsp_flag, ex.flag);
          end
          last_id = rsp_id; last_data = rsp_data; last_flag = rsp_flag;
          midle = 1;
        end
        hold_v = rsp_valid && !rsp_ready;
        h_id = rsp_id; h_data = rsp_data; h_flag = rsp_flag;
      end
    end
  end

  task automatic drain(input int bound);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid &&
             !req1_valid && sb.size() == 0 && midle && !rsp_valid)) begin
      @(negedge clk);
      n++;
      if (n > bound) begin fail_now("drain_timeout"); break; end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_val();
    unique case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    op_t tmp;
    int  k, n;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flag", rsp_flag, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_alu_fn", alu_funct, 0);
    chk("rst_alu_a", alu_srca, 0);
    chk("rst_alu_b", alu_srcb, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    @(posedge clk); #3 rst = 0;

    q0.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'd5, b: 32'd7});
    drain(50);
    chk("t1_id", last_id, 0);
    chk("t1_data", last_data, 12);
    chk("t1_flag", last_flag, 0);

    q1.push_back('{op: OP_RTYPE, fn: FN_SUB, a: 32'd10, b: 32'd3});
    drain(50);
    chk("sub_id", last_id, 1);
    chk("sub_data", last_data, 7);

    q0.push_back('{op: OP_RTYPE, fn: FN_XOR, a: 32'hF0F0F0F0, b: 32'hFFFF0000});
    drain(50);
    chk("xor_data", last_data, 32'h0F0FF0F0);

    q0.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'hFFFFFFFF, b: 32'd1});
    drain(50);
    chk("ovf_data", last_data, 0);
    chk("ovf_flag", last_flag, 1);

    rdy_force = 0;
    q0.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'd100, b: 32'd23});
    n = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 20) begin fail_now("bp_wait"); break; end
    end
    q1.push_back('{op: OP_XORI, fn: 6'd0, a: 32'd3, b: 32'd1});
    repeat (5) @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_data", rsp_data, 123);
    @(posedge clk); #1 rdy_force = 1;
    drain(50);
    chk("bp_next", last_data, 2);

    q0.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'd1, b: 32'd1});
    k = acc_ids.size();
    n = 0;
    while (acc_ids.size() == k) begin
      @(negedge clk);
      n++;
      if (n > 20) begin fail_now("mid_wait"); break; end
    end
    @(posedge clk); #3 rst = 1;
    @(negedge clk);
    chk("mid_valid", rsp_valid, 0);
    chk("mid_alu_op", alu_opcode, 0);
    chk("mid_alu_a", alu_srca, 0);
    chk("mid_alu_b", alu_srcb, 0);
    @(posedge clk); #3 rst = 0;
    q1.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'd40, b: 32'd2});
    drain(50);
    chk("mid_next_id", last_id, 1);
    chk("mid_next_data", last_data, 42);

    acc_ids.delete(); acc_cycs.delete();
    q0.push_back('{op: OP_ADDI, fn: 6'd0, a: 32'd1, b: 32'd2});
    q0.push_back('{op: OP_XORI, fn: 6'd0, a: 32'hFF, b: 32'h0F});
    q1.push_back('{op: OP_RTYPE, fn: FN_ADD, a: 32'd8, b: 32'd9});
    q1.push_back('{op: OP_RTYPE, fn: FN_SUB, a: 32'd0, b: 32'd1});
    drain(80);
    chk("fair_cnt", acc_ids.size(), 4);
    if (acc_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("fair_id", acc_ids[i], i % 2);
        if (i > 0) chk("fair_gap", acc_cycs[i] - acc_cycs[i-1], 3);
      end
    end

    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      tmp.op = (k == 0) ? OP_ADDI : (k == 1) ? OP_XORI : OP_RTYPE;
      tmp.fn = (k == 2) ? FN_ADD : (k == 3) ? FN_SUB : (k == 4) ? FN_XOR : 6'd0;
      tmp.a = pick_val();
      tmp.b = pick_val();
      if ($urandom_range(0, 1) == 1) q1.push_back(tmp);
      else q0.push_back(tmp);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    drain(2000);
    rand_rdy = 0;
    drain(50);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
